// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: bundles the requester, response and multiplier-side signals
// of mul_arbiter.
//   slave  : the arbiter's view (takes requests, drives acks/response/multiplier)
//   master : the environment's view (requesters, consumer, multiplier)
// Signal groups:
//   req0/x0/y0/ack0, req1/x1/y1/ack1     requester handshakes
//   rsp_valid/rsp_ready/rsp_id/rsp_err/rsp_product   shared response bus
//   busy                                 arbiter not idle
//   mul_start/mul_x/mul_y/mul_done/mul_product       multiplier port
interface mul_arbiter_if;
  logic        req0;
  logic [31:0] x0;
  logic [31:0] y0;
  logic        ack0;
  logic        req1;
  logic [31:0] x1;
  logic [31:0] y1;
  logic        ack1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_err;
  logic [66:0] rsp_product;
  logic        busy;
  logic        mul_start;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_done;
  logic [66:0] mul_product;

  modport slave (
    input  req0, x0, y0, req1, x1, y1, rsp_ready, mul_done, mul_product,
    output ack0, ack1, rsp_valid, rsp_id, rsp_err, rsp_product, busy,
           mul_start, mul_x, mul_y
  );

  modport master (
    output req0, x0, y0, req1, x1, y1, rsp_ready, mul_done, mul_product,
    input  ack0, ack1, rsp_valid, rsp_id, rsp_err, rsp_product, busy,
           mul_start, mul_x, mul_y
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one Booth multiplier between two requesters.
// Round-robin grant, latched operands, one-cycle start pulse, watchdog on the
// multiplier's done pulse, and a valid/ready response carrying the 67-bit
// signed product (or an error flag with a zero product on timeout).
// Ports:
//   clk   : clock, all state on rising edge
//   rst_b : asynchronous active-low reset
//   bus   : mul_arbiter_if.slave (requesters, response bus, multiplier port)
// Every output is a flop; no input reaches an output combinationally.
module mul_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input logic         clk,
  input logic         rst_b,
  mul_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_last;
  logic            r_id;
  logic [TW-1:0]   r_wdog;
  logic [31:0]     r_mul_x, r_mul_y;
  logic [66:0]     r_prod;
  logic            r_err;
  logic            r_ack0, r_ack1, r_start, r_valid, r_busy;

  logic [1:0]      w_req;
  logic            w_grant;
  logic            w_gid;
  logic            w_expire;

  assign w_req    = {bus.req1, bus.req0};
  // Last WAIT cycle: counter runs 0..TIMEOUT-1, so WAIT lasts TIMEOUT cycles.
  assign w_expire = (r_wdog == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gid       = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant = |w_req;
        case (w_req)
          2'b10:   w_gid = 1'b1;
          2'b11:   w_gid = ~r_last;   // tie goes to whoever was not served last
          default: w_gid = 1'b0;
        endcase
        if (w_grant) w_state_nxt = ISSUE;
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT:  if (bus.mul_done || w_expire) w_state_nxt = RESP;
      RESP:  if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_wdog  <= '0;
      r_mul_x <= '0;
      r_mul_y <= '0;
      r_prod  <= '0;
      r_err   <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_start <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // Strobes are registered from the grant so they appear exactly in ISSUE.
      r_ack0  <= w_grant & ~w_gid;
      r_ack1  <= w_grant &  w_gid;
      r_start <= w_grant;
      r_busy  <= (w_state_nxt != IDLE);
      r_valid <= (w_state_nxt == RESP);
      case (r_state)
        IDLE: if (w_grant) begin
          r_id    <= w_gid;
          r_mul_x <= w_gid ? bus.x1 : bus.x0;
          r_mul_y <= w_gid ? bus.y1 : bus.y0;
        end
        ISSUE: r_wdog <= '0;
        WAIT: begin
          // done is checked first so a done in the expiry cycle is not an error
          if (bus.mul_done) begin
            r_prod <= bus.mul_product;
            r_err  <= 1'b0;
          end else if (w_expire) begin
            r_prod <= '0;
            r_err  <= 1'b1;
          end else begin
            r_wdog <= r_wdog + TW'(1);
          end
        end
        RESP: if (bus.rsp_ready) r_last <= r_id;
        default: ;
      endcase
    end
  end

  assign bus.ack0        = r_ack0;
  assign bus.ack1        = r_ack1;
  assign bus.mul_start   = r_start;
  assign bus.mul_x       = r_mul_x;
  assign bus.mul_y       = r_mul_y;
  assign bus.busy        = r_busy;
  assign bus.rsp_valid   = r_valid;
  assign bus.rsp_id      = r_id;
  assign bus.rsp_err     = r_err;
  assign bus.rsp_product = r_prod;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: self-checking bench for mul_arbiter.
// A behavioural multiplier answers mul_start after a programmable delay; a
// scoreboard queue holds expected responses, popped on each rsp handshake.
module tb_mul_arbiter;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  mul_arbiter_if bus();

  mul_arbiter #(.TIMEOUT(TIMEOUT), .TW(7)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
  );

  typedef struct {
    logic        who;
    logic [31:0] x;
    logic [31:0] y;
    int          dly;
    logic [66:0] prod;
    logic        err;
  } vec_t;

  typedef struct {
    logic        id;
    logic        err;
    logic [66:0] prod;
  } exp_t;

  exp_t sb[$];
  logic ackq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  int          md_delay = 20;
  int          md_cnt   = 0;
  bit          md_stray = 1'b0;
  bit          md_kill  = 1'b0;
  logic [66:0] md_prod  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [66:0] sx(input logic [31:0] v);
    return {{35{v[31]}}, v};
  endfunction

  task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Multiplier model: done arrives md_delay cycles after the start cycle.
  initial begin
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
    forever begin
      @(negedge clk);
      bus.mul_done    = 1'b0;
      bus.mul_product = '0;
      if (md_kill) begin
        md_cnt  = 0;
        md_kill = 1'b0;
      end
      if (md_stray) begin
        bus.mul_done    = 1'b1;
        bus.mul_product = 67'h1234;
        md_stray        = 1'b0;
      end
      if (md_cnt > 0) begin
        md_cnt--;
        if (md_cnt == 0) begin
          bus.mul_done    = 1'b1;
          bus.mul_product = md_prod;
        end
      end
      if (rst_b && bus.mul_start && md_delay > 0) begin
        md_cnt  = md_delay;
        md_prod = sx(bus.mul_x) * sx(bus.mul_y);
      end
    end
  end

  // Monitor: ack exclusivity, grant log, scoreboard pop on response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        chk("one_ack", bus.ack0 & bus.ack1, 1'b0);
        if (bus.ack0) ackq.push_back(1'b0);
        if (bus.ack1) ackq.push_back(1'b1);
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got id=%0d prod=%0h, expected no response",
                     bus.rsp_id, bus.rsp_product);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", bus.rsp_id, e.id);
            chk("rsp_err", bus.rsp_err, e.err);
            chk("rsp_product", bus.rsp_product, e.prod);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout_fail("drain");
      sb.delete();
    end
    @(negedge clk);
    chk("idle_after_rsp", bus.busy, 1'b0);
  endtask

  task automatic wait_ack(input logic who, input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if ((who && bus.ack1) || (!who && bus.ack0)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("ack");
  endtask

  task automatic run_vec(input vec_t v);
    md_delay = v.dly;
    @(posedge clk); #1;
    if (v.who) begin
      bus.req1 = 1'b1; bus.x1 = v.x; bus.y1 = v.y;
    end else begin
      bus.req0 = 1'b1; bus.x0 = v.x; bus.y0 = v.y;
    end
    sb.push_back('{v.who, v.err, v.prod});
    @(negedge clk);
    chk("ack_not_early", {bus.ack1, bus.ack0}, 2'b00);
    @(negedge clk);
    chk("ack_latency", {bus.ack1, bus.ack0}, v.who ? 2'b10 : 2'b01);
    chk("start_pulse", bus.mul_start, 1'b1);
    chk("mul_x", bus.mul_x, v.x);
    chk("mul_y", bus.mul_y, v.y);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    chk("start_one_cycle", bus.mul_start, 1'b0);
    wait_drain(300);
  endtask

  vec_t tbl[6];

  initial begin
    int t0, t1;
    bit ok;
    bus.req0 = 1'b0; bus.x0 = '0; bus.y0 = '0;
    bus.req1 = 1'b0; bus.x1 = '0; bus.y1 = '0;
    bus.rsp_ready = 1'b1;

    tbl[0] = '{1'b0, 32'd172,        32'd172,        20, 67'sd29584,               1'b0};
    tbl[1] = '{1'b1, -32'sd3,        32'sd5,         20, -67'sd15,                 1'b0};
    tbl[2] = '{1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  1,  67'h3FFF_FFFF_0000_0001,  1'b0};
    tbl[3] = '{1'b1, 32'h8000_0000,  32'h8000_0000,  63, 67'h4000_0000_0000_0000,  1'b0};
    // done in the expiry cycle itself: done wins
    tbl[4] = '{1'b0, 32'h8000_0000,  32'h7FFF_FFFF,  64, -67'sd4611686016279904256, 1'b0};
    // done one cycle too late: abort, and the late done lands in RESP
    tbl[5] = '{1'b1, 32'd5,          32'd5,          65, 67'd0,                    1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ctl", {bus.ack0, bus.ack1, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                    bus.busy, bus.mul_start}, 7'd0);
    chk("rst_prod", bus.rsp_product, 67'd0);
    chk("rst_ops", {bus.mul_x, bus.mul_y}, 64'd0);
    rst_b = 1'b1;

    // simultaneous requests held: alternate grants starting with requester 0
    md_delay = 3;
    ackq.delete();
    sb.push_back('{1'b0, 1'b0, 67'sd6});
    sb.push_back('{1'b1, 1'b0, -67'sd20});
    sb.push_back('{1'b0, 1'b0, 67'sd6});
    sb.push_back('{1'b1, 1'b0, -67'sd20});
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.x0 = 32'd2;   bus.y0 = 32'd3;
    bus.req1 = 1'b1; bus.x1 = -32'sd4; bus.y1 = 32'd5;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1 || bus.rsp_valid) chk("busy_in_txn", bus.busy, 1'b1);
      if (ackq.size() >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("rr_acks");
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_drain(300);
    chk("rr_count", ackq.size(), 4);
    for (int i = 0; i < 4 && i < ackq.size(); i++)
      chk("rr_order", ackq[i], (i % 2 == 1) ? 1'b1 : 1'b0);

    // table-driven single transactions
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // watchdog: multiplier never answers
    md_delay = 0;
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.x0 = 32'd7; bus.y0 = 32'd9;
    sb.push_back('{1'b0, 1'b1, 67'd0});
    wait_ack(1'b0, 10);
    t0 = cyc;
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    t1 = cyc;
    if (!ok) timeout_fail("wdog_rsp");
    chk("wdog_latency", t1 - t0, TIMEOUT + 1);
    chk("wdog_err", bus.rsp_err, 1'b1);
    chk("wdog_prod", bus.rsp_product, 67'd0);
    wait_drain(10);
    // stray done while idle must not create a response
    md_stray = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stray_no_rsp", bus.rsp_valid, 1'b0);
      chk("stray_idle", bus.busy, 1'b0);
    end

    // stalled consumer with a pending request from the other side
    md_delay = 4;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req1 = 1'b1; bus.x1 = 32'd11; bus.y1 = -32'sd7;
    sb.push_back('{1'b1, 1'b0, -67'sd77});
    wait_ack(1'b1, 10);
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.x0 = 32'd1; bus.y0 = -32'sd1;
    sb.push_back('{1'b0, 1'b0, -67'sd1});
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("stall_rsp");
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", bus.rsp_valid, 1'b1);
      chk("stall_id", bus.rsp_id, 1'b1);
      chk("stall_err", bus.rsp_err, 1'b0);
      chk("stall_prod", bus.rsp_product, -67'sd77);
      chk("stall_no_ack", {bus.ack1, bus.ack0}, 2'b00);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_ack(1'b0, 10);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    wait_drain(100);

    // asynchronous reset in the middle of WAIT
    md_delay = 30;
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.x0 = 32'd3; bus.y0 = 32'd3;
    wait_ack(1'b0, 10);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_b = 1'b0;
    md_kill = 1'b1;
    sb.delete();
    #1;
    chk("midrst_ctl", {bus.ack0, bus.ack1, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                       bus.busy, bus.mul_start}, 7'd0);
    chk("midrst_prod", bus.rsp_product, 67'd0);
    chk("midrst_ops", {bus.mul_x, bus.mul_y}, 64'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    begin
      vec_t v;
      v = '{1'b0, 32'd12, 32'd13, 5, 67'sd156, 1'b0};
      run_vec(v);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
